// File: rtl/sram_read_ctrl.sv
// sram_read_ctrl
//   Read-only controller for the 16-bit asynchronous background-image SRAM.
//   The background loader holds `reading` high and presents ADDR. This block
//   runs one timed read cycle per accepted request and returns the word on
//   DATA_OUT. It pulses SRAM_done for one cycle when the word is valid.
//   end_marker flags the all-ones end-of-image word.
//
// Ports
//   Clk         system clock, rising edge
//   Reset       asynchronous, active-high reset
//   reading     level read request from the loader
//   ADDR        word address, sampled when a request is accepted
//   DATA_OUT    last captured SRAM word (registered)
//   SRAM_done   one-cycle pulse, DATA_OUT valid in that cycle
//   end_marker  DATA_OUT is the all-ones marker word
//   SRAM_ADDR   address pins to the SRAM
//   SRAM_CE_N   chip enable, active low
//   SRAM_OE_N   output enable, active low
//   SRAM_WE_N   write enable, tied inactive
//   SRAM_UB_N   upper byte enable, follows CE_N
//   SRAM_LB_N   lower byte enable, follows CE_N
//   SRAM_DQ     SRAM data bus, never driven by this block
module sram_read_ctrl #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              reading,
    input  logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              SRAM_done,
    output logic              end_marker,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    inout  wire  [DATA_W-1:0] SRAM_DQ
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_CAPTURE,
        S_DONE,
        S_HOLD
    } state_t;

    state_t            state;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] addr_q;

    // The pin outputs are registered and set on the edge that enters each
    // state. This keeps them glitch-free. For example, CE_N falls on the
    // accepting edge, so it is already low throughout SETUP.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            addr_q    <= '0;
            DATA_OUT  <= '0;
            SRAM_done <= 1'b0;
            SRAM_ADDR <= '0;
            SRAM_CE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
        end else begin
            SRAM_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (reading) begin
                        addr_q    <= ADDR;
                        SRAM_ADDR <= ADDR;
                        SRAM_CE_N <= 1'b0;
                        SRAM_OE_N <= 1'b1;
                        state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    wait_cnt  <= WAIT_INIT;
                    SRAM_ADDR <= addr_q;
                    SRAM_OE_N <= 1'b0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    // Loaded with WAIT_CYCLES. Leaving on the count of 1
                    // gives exactly WAIT_CYCLES cycles in this state.
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    DATA_OUT  <= SRAM_DQ;
                    SRAM_CE_N <= 1'b1;
                    SRAM_OE_N <= 1'b1;
                    SRAM_done <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    state <= S_HOLD;
                end
                S_HOLD: begin
                    // A request that is still held high must not start a
                    // second read. Wait for the loader to drop it.
                    if (!reading) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    SRAM_CE_N <= 1'b1;
                    SRAM_OE_N <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    assign SRAM_WE_N  = 1'b1;
    assign SRAM_UB_N  = SRAM_CE_N;
    assign SRAM_LB_N  = SRAM_CE_N;
    assign SRAM_DQ    = {DATA_W{1'bz}};
    assign end_marker = (DATA_OUT == {DATA_W{1'b1}});

endmodule

// File: tb/tb_sram_read_ctrl.sv
module tb_sram_read_ctrl;

    localparam int AW = 20;
    localparam int DW = 16;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          reading = 1'b0;
    logic [AW-1:0] ADDR = '0;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Behavioural SRAM contents used by all instances
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        case (a)
            20'd307200: mem_word = 16'h1234;
            20'd0:      mem_word = 16'h00AA;
            20'd1:      mem_word = 16'h00BB;
            20'hFFFFF:  mem_word = 16'hFFFF;
            20'd5:      mem_word = 16'hF0FF;
            default:    mem_word = a[15:0] ^ 16'h5A5A;
        endcase
    endfunction

    // Default build (WAIT_CYCLES = 2)
    logic [DW-1:0] do2;
    logic [AW-1:0] sa2;
    logic done2, em2, ce2, oe2, we2, ub2, lb2;
    wire  [DW-1:0] dq2;
    assign dq2 = (!ce2 && !oe2) ? mem_word(sa2) : {DW{1'bz}};

    sram_read_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2)) u_dut (
        .Clk(Clk), .Reset(Reset), .reading(reading), .ADDR(ADDR),
        .DATA_OUT(do2), .SRAM_done(done2), .end_marker(em2),
        .SRAM_ADDR(sa2), .SRAM_CE_N(ce2), .SRAM_OE_N(oe2), .SRAM_WE_N(we2),
        .SRAM_UB_N(ub2), .SRAM_LB_N(lb2), .SRAM_DQ(dq2)
    );

    // WAIT_CYCLES = 1 build
    logic [DW-1:0] do1;
    logic [AW-1:0] sa1;
    logic done1, em1, ce1, oe1, we1, ub1, lb1;
    wire  [DW-1:0] dq1;
    assign dq1 = (!ce1 && !oe1) ? mem_word(sa1) : {DW{1'bz}};

    sram_read_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) u_w1 (
        .Clk(Clk), .Reset(Reset), .reading(reading), .ADDR(ADDR),
        .DATA_OUT(do1), .SRAM_done(done1), .end_marker(em1),
        .SRAM_ADDR(sa1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1), .SRAM_WE_N(we1),
        .SRAM_UB_N(ub1), .SRAM_LB_N(lb1), .SRAM_DQ(dq1)
    );

    // WAIT_CYCLES = 15 build
    logic [DW-1:0] do15;
    logic [AW-1:0] sa15;
    logic done15, em15, ce15, oe15, we15, ub15, lb15;
    wire  [DW-1:0] dq15;
    assign dq15 = (!ce15 && !oe15) ? mem_word(sa15) : {DW{1'bz}};

    sram_read_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(15)) u_w15 (
        .Clk(Clk), .Reset(Reset), .reading(reading), .ADDR(ADDR),
        .DATA_OUT(do15), .SRAM_done(done15), .end_marker(em15),
        .SRAM_ADDR(sa15), .SRAM_CE_N(ce15), .SRAM_OE_N(oe15), .SRAM_WE_N(we15),
        .SRAM_UB_N(ub15), .SRAM_LB_N(lb15), .SRAM_DQ(dq15)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Ticks until done2 is seen. The result is the number of edges taken,
    // bounded at 30.
    task automatic wait_done(output int n);
        n = 0;
        while (!done2 && n < 30) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int dn;
        int cel;
        int acc1;
        int oec2, oec1, oec15;
        int at2, at1, at15;
        int dc2, dc1, dc15;

        // 1. Reset held with reading high
        Reset = 1'b1; reading = 1'b1; ADDR = 20'd307200;
        tick(); tick();
        check("rst_pins2",  {27'd0, ce2, oe2, we2, ub2, lb2}, 32'h1F);
        check("rst_pins1",  {27'd0, ce1, oe1, we1, ub1, lb1}, 32'h1F);
        check("rst_pins15", {27'd0, ce15, oe15, we15, ub15, lb15}, 32'h1F);
        check("rst_data",   {do15, do2}, 32'h0);
        check("rst_data1",  {16'd0, do1}, 32'h0);
        check("rst_flags",  {29'd0, done2, em2, em1 | em15}, 32'h0);
        check("rst_addr",   {12'd0, sa2}, 32'h0);

        // 2. Single read with reading held high
        Reset = 1'b0;
        tick();                               // edge 0: accepted
        check("t2_setup_ce",   {31'd0, ce2}, 32'h0);
        check("t2_setup_oe",   {31'd0, oe2}, 32'h1);
        check("t2_setup_addr", {12'd0, sa2}, 32'd307200);
        ADDR = 20'h0ABCD;                     // must be ignored from here on
        tick();                               // edge 1: WAIT
        check("t2_wait1_oe",   {30'd0, ce2, oe2}, 32'h0);
        check("t2_wait1_addr", {12'd0, sa2}, 32'd307200);
        tick();                               // edge 2: WAIT
        check("t2_wait2_oe",   {31'd0, oe2}, 32'h0);
        tick();                               // edge 3: CAPTURE
        check("t2_cap_pins",   {29'd0, ce2, oe2, done2}, 32'h0);
        check("t2_cap_addr",   {12'd0, sa2}, 32'd307200);
        tick();                               // edge 4: DONE
        check("t2_done",       {31'd0, done2}, 32'h1);
        check("t2_data",       {16'd0, do2}, 32'h1234);
        check("t2_done_pins",  {30'd0, ce2, oe2}, 32'h3);
        dn = 0; cel = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done2) dn++;
            if (!ce2) cel++;
        end
        check("t2_no_repeat_done", dn, 0);
        check("t2_no_repeat_ce",   cel, 0);
        check("t2_data_held",      {16'd0, do2}, 32'h1234);

        // 3. Back-to-back pulsed requests
        reading = 1'b0;
        tick();                               // HOLD -> IDLE
        reading = 1'b1; ADDR = 20'd0;
        tick();
        acc1 = cyc;
        reading = 1'b0;
        wait_done(n);
        check("t3_lat_a",  n, 4);
        check("t3_data_a", {16'd0, do2}, 32'h00AA);
        tick(); tick();                       // DONE -> HOLD -> IDLE
        reading = 1'b1; ADDR = 20'd1;
        tick();
        check("t3_accept_b", {31'd0, ce2}, 32'h0);
        check("t3_spacing",  cyc - acc1, 7);
        reading = 1'b0;
        wait_done(n);
        check("t3_lat_b",  n, 4);
        check("t3_data_b", {16'd0, do2}, 32'h00BB);
        check("t3_em_b",   {31'd0, em2}, 32'h0);

        // 4. End-of-image marker at top address, then a near-miss word
        tick(); tick();
        reading = 1'b1; ADDR = 20'hFFFFF;
        tick();
        reading = 1'b0;
        check("t4_addr_top", {12'd0, sa2}, 32'hFFFFF);
        wait_done(n);
        check("t4_data_ffff", {16'd0, do2}, 32'hFFFF);
        check("t4_em_done",   {31'd0, em2}, 32'h1);
        tick();
        check("t4_em_hold",   {31'd0, em2}, 32'h1);
        tick();
        reading = 1'b1; ADDR = 20'd5;
        tick();
        reading = 1'b0;
        check("t4_em_kept",   {31'd0, em2}, 32'h1);
        wait_done(n);
        check("t4_data_f0ff", {16'd0, do2}, 32'hF0FF);
        check("t4_em_clear",  {31'd0, em2}, 32'h0);

        // 5. reading dropped in WAIT, then reset during WAIT
        tick(); tick();
        reading = 1'b1; ADDR = 20'h12345;
        tick();                               // edge 0
        tick();                               // edge 1: WAIT
        reading = 1'b0;
        wait_done(n);
        check("t5_lat_drop",  n, 3);
        check("t5_data_drop", {16'd0, do2}, 32'h791F);
        tick();                               // edge 5: HOLD
        tick();                               // edge 6: IDLE
        reading = 1'b1; ADDR = 20'h00042;
        tick();                               // edge 7: accepted
        check("t5_hold_exit", {31'd0, ce2}, 32'h0);
        tick(); tick();                       // now in WAIT
        check("t5_pre_rst_oe", {31'd0, oe2}, 32'h0);
        Reset = 1'b1;
        #1;
        check("t5_rst_pins", {27'd0, ce2, oe2, we2, ub2, lb2}, 32'h1F);
        check("t5_rst_data", {15'd0, done2, do2}, 32'h0);
        tick(); tick();
        Reset = 1'b0; reading = 1'b0;
        dn = 0; cel = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done2) dn++;
            if (!ce2) cel++;
        end
        check("t5_no_done", dn, 0);
        check("t5_idle_ce", cel, 0);

        // 6. WAIT_CYCLES = 1 / 2 / 15 timing
        Reset = 1'b1; tick();
        Reset = 1'b0; tick();
        reading = 1'b1; ADDR = 20'd7;
        tick();
        reading = 1'b0;
        oec2 = 0; oec1 = 0; oec15 = 0;
        at2 = 0; at1 = 0; at15 = 0;
        dc2 = 0; dc1 = 0; dc15 = 0;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (!oe2)  oec2++;
            if (!oe1)  oec1++;
            if (!oe15) oec15++;
            if (done2)  begin dc2++;  if (at2 == 0)  at2 = k;  end
            if (done1)  begin dc1++;  if (at1 == 0)  at1 = k;  end
            if (done15) begin dc15++; if (at15 == 0) at15 = k; end
        end
        check("t6_oe_w2",    oec2, 3);
        check("t6_oe_w1",    oec1, 2);
        check("t6_oe_w15",   oec15, 16);
        check("t6_lat_w2",   at2, 4);
        check("t6_lat_w1",   at1, 3);
        check("t6_lat_w15",  at15, 17);
        check("t6_cnt_w2",   dc2, 1);
        check("t6_cnt_w1",   dc1, 1);
        check("t6_cnt_w15",  dc15, 1);
        check("t6_data_w1",  {16'd0, do1}, 32'h5A5D);
        check("t6_data_w15", {16'd0, do15}, 32'h5A5D);
        check("t6_addr_w15", {12'd0, sa15}, 32'd7);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
